// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency memory between instruction fetch and the
// data port: one access in flight, data-first arbitration with a fetch starvation guard.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W     = $clog2(MEM_LAT + 1);
    localparam int unsigned STV_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    logic               r_own_if;
    logic               r_we;
    logic               r_kill;
    logic [CNT_W-1:0]   r_cnt;
    logic [STV_W-1:0]   r_starve;

    logic               w_any_req;
    logic               w_starved;
    logic               w_grant_if;
    logic               w_flush_hit;
    logic               w_last_wait;

    assign w_any_req   = if_req | d_req;
    assign w_starved   = (r_starve == STV_W'(STARVE_LIMIT));
    assign w_grant_if  = if_req & (~d_req | w_starved);
    assign w_flush_hit = if_flush & r_own_if;
    assign w_last_wait = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_own_if  <= 1'b0;
            r_we      <= 1'b0;
            r_kill    <= 1'b0;
            r_cnt     <= '0;
            r_starve  <= '0;
            if_ack    <= 1'b0;
            if_rdata  <= '0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state   <= S_ACCESS;
                        r_own_if  <= w_grant_if;
                        r_we      <= ~w_grant_if & d_we;
                        r_kill    <= 1'b0;
                        mem_en    <= 1'b1;
                        mem_we    <= ~w_grant_if & d_we;
                        mem_addr  <= (w_grant_if ? if_addr : d_addr) & ADDR_MASK;
                        mem_wdata <= w_grant_if ? 32'h0 : d_wdata;
                        // Count only data grants that actually made fetch wait
                        if (w_grant_if) begin
                            r_starve <= '0;
                        end else if (if_req) begin
                            if (!w_starved) begin
                                r_starve <= r_starve + STV_W'(1);
                            end
                        end else begin
                            r_starve <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    r_cnt   <= CNT_W'(MEM_LAT);
                    r_state <= S_WAIT;
                    if (w_flush_hit) begin
                        r_kill <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_flush_hit) begin
                        r_kill <= 1'b1;
                    end
                    if (w_last_wait) begin
                        r_state <= S_RESP;
                        // A flush arriving in this very cycle must also cancel the fetch
                        if (r_own_if) begin
                            if (!(r_kill | if_flush)) begin
                                if_rdata <= mem_rdata;
                                if_ack   <= 1'b1;
                            end
                        end else begin
                            if (!r_we) begin
                                d_rdata <= mem_rdata;
                            end
                            d_ack <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if_ack  <= 1'b0;
                    d_ack   <= 1'b0;
                    r_kill  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3,
// each backed by a small fixed-latency memory model.
module tb_mem_port_arbiter;

    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 3;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic        a_if_ack, a_d_ack, a_mem_en, a_mem_we;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        b_if_ack, b_d_ack, b_mem_en, b_mem_we;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    int n_checks;
    int n_errors;

    mem_port_arbiter #(.MEM_LAT(LAT_A), .STARVE_LIMIT(4)) u_dut_a (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(a_if_ack), .if_rdata(a_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(a_d_ack), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(LAT_B), .STARVE_LIMIT(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: read data is valid only in the cycle exactly LAT after mem_en
    logic [31:0] mem_a [0:15];
    logic [31:0] mem_b [0:15];
    logic [31:0] pipe_a_d [0:LAT_A-1];
    logic        pipe_a_v [0:LAT_A-1];
    logic [31:0] pipe_b_d [0:LAT_B-1];
    logic        pipe_b_v [0:LAT_B-1];

    function automatic logic [31:0] init_word(input int i);
        case (i)
            2:       init_word = 32'hE021_3000;
            3:       init_word = 32'h1122_3344;
            4:       init_word = 32'hA5A5_5A5A;
            8:       init_word = 32'h00C0_FFEE;
            default: init_word = 32'h5000_0000 + 32'(i);
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem_a[i] <= init_word(i);
            for (int i = 0; i < LAT_A; i++) pipe_a_v[i] <= 1'b0;
        end else begin
            if (a_mem_en && a_mem_we) mem_a[a_mem_addr[5:2]] <= a_mem_wdata;
            pipe_a_v[0] <= a_mem_en && !a_mem_we;
            pipe_a_d[0] <= mem_a[a_mem_addr[5:2]];
            for (int i = 1; i < LAT_A; i++) begin
                pipe_a_v[i] <= pipe_a_v[i-1];
                pipe_a_d[i] <= pipe_a_d[i-1];
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem_b[i] <= init_word(i);
            for (int i = 0; i < LAT_B; i++) pipe_b_v[i] <= 1'b0;
        end else begin
            if (b_mem_en && b_mem_we) mem_b[b_mem_addr[5:2]] <= b_mem_wdata;
            pipe_b_v[0] <= b_mem_en && !b_mem_we;
            pipe_b_d[0] <= mem_b[b_mem_addr[5:2]];
            for (int i = 1; i < LAT_B; i++) begin
                pipe_b_v[i] <= pipe_b_v[i-1];
                pipe_b_d[i] <= pipe_b_d[i-1];
            end
        end
    end

    assign a_mem_rdata = pipe_a_v[LAT_A-1] ? pipe_a_d[LAT_A-1] : 32'hBAD0_BAD0;
    assign b_mem_rdata = pipe_b_v[LAT_B-1] ? pipe_b_d[LAT_B-1] : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, ".if_ack"},    32'(a_if_ack),  32'h0);
        check({tag, ".d_ack"},     32'(a_d_ack),   32'h0);
        check({tag, ".mem_en"},    32'(a_mem_en),  32'h0);
        check({tag, ".mem_we"},    32'(a_mem_we),  32'h0);
        check({tag, ".mem_addr"},  a_mem_addr,     32'h0);
        check({tag, ".mem_wdata"}, a_mem_wdata,    32'h0);
        check({tag, ".if_rdata"},  a_if_rdata,     32'h0);
        check({tag, ".d_rdata"},   a_d_rdata,      32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    int n_grants;
    logic grant_is_if [0:9];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        if_flush = 1'b0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = 32'h0;
        d_wdata  = 32'h0;
        tick();
        tick();
        check_a_zero("reset_init");
        reset = 1'b0;
        tick();

        // Single fetch, MEM_LAT=1
        if_req  = 1'b1;
        if_addr = 32'h08;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("fetch.mem_en", 32'(a_mem_en), 32'(c == 1));
            check("fetch.if_ack", 32'(a_if_ack), 32'(c == 3));
            check("fetch.d_ack",  32'(a_d_ack),  32'h0);
            if (c == 1) begin
                check("fetch.mem_addr", a_mem_addr, 32'h08);
                check("fetch.mem_we",   32'(a_mem_we), 32'h0);
            end
            if (c == 3) begin
                check("fetch.if_rdata", a_if_rdata, 32'hE021_3000);
                if_req = 1'b0;
            end
        end

        // Contention: data wins first, fetch follows
        if_req  = 1'b1;
        if_addr = 32'h0C;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h22;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("cont.mem_en", 32'(a_mem_en), 32'(c == 1 || c == 5));
            check("cont.d_ack",  32'(a_d_ack),  32'(c == 3));
            check("cont.if_ack", 32'(a_if_ack), 32'(c == 7));
            if (c == 1) check("cont.d_addr", a_mem_addr, 32'h20);
            if (c == 5) check("cont.i_addr", a_mem_addr, 32'h0C);
            if (c == 3) begin
                check("cont.d_rdata", a_d_rdata, 32'h00C0_FFEE);
                d_req = 1'b0;
            end
            if (c == 7) begin
                check("cont.if_rdata", a_if_rdata, 32'h1122_3344);
                if_req = 1'b0;
            end
        end

        // Store leaves d_rdata untouched
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h08;
        d_wdata = 32'h00C0_FFEF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("st.mem_en", 32'(a_mem_en), 32'(c == 1));
            check("st.mem_we", 32'(a_mem_we), 32'(c == 1));
            check("st.d_ack",  32'(a_d_ack),  32'(c == 3));
            if (c == 1) begin
                check("st.mem_addr",  a_mem_addr,  32'h08);
                check("st.mem_wdata", a_mem_wdata, 32'h00C0_FFEF);
            end
            if (c == 3) begin
                check("st.d_rdata", a_d_rdata, 32'h00C0_FFEE);
                d_req = 1'b0;
                d_we  = 1'b0;
            end
        end

        // Misaligned load reads back the stored word
        d_req  = 1'b1;
        d_addr = 32'h0A;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) check("mis.mem_addr", a_mem_addr, 32'h08);
            if (c == 3) begin
                check("mis.d_ack",   32'(a_d_ack), 32'h1);
                check("mis.d_rdata", a_d_rdata,    32'h00C0_FFEF);
                d_req = 1'b0;
            end
        end

        // Build up starvation count, then reset in the WAIT of the third data access
        if_req  = 1'b1;
        if_addr = 32'h10;
        d_req   = 1'b1;
        d_addr  = 32'h20;
        for (int c = 1; c <= 10; c++) tick();
        check("pre_rst.d_rdata",  a_d_rdata,  32'h00C0_FFEE);
        check("pre_rst.mem_addr", a_mem_addr, 32'h20);
        reset = 1'b1;
        #1;
        check_a_zero("rst_async");
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("post_rst.if_ack", 32'(a_if_ack), 32'h0);
            check("post_rst.d_ack",  32'(a_d_ack),  32'h0);
            check("post_rst.mem_en", 32'(a_mem_en), 32'h0);
        end

        // Starvation guard: D,D,D,D,I repeating, from a cleared count
        if_req   = 1'b1;
        if_addr  = 32'h10;
        d_req    = 1'b1;
        d_addr   = 32'h20;
        n_grants = 0;
        for (int c = 1; c <= 42; c++) begin
            tick();
            check("starve.ack_excl", 32'(a_if_ack & a_d_ack), 32'h0);
            if (a_mem_en && n_grants < 10) begin
                grant_is_if[n_grants] = (a_mem_addr == 32'h10);
                n_grants++;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        check("starve.n_grants", 32'(n_grants), 32'd10);
        for (int k = 0; k < 10; k++) begin
            if (k < n_grants) check($sformatf("starve.grant%0d", k), 32'(grant_is_if[k]), 32'(k % 5 == 4));
        end
        for (int c = 1; c <= 6; c++) tick();

        // Flush on the MEM_LAT=3 instance
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        if_req  = 1'b1;
        if_addr = 32'h0C;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("bfetch.mem_en", 32'(b_mem_en), 32'(c == 1));
            check("bfetch.if_ack", 32'(b_if_ack), 32'(c == 5));
            if (c == 5) begin
                check("bfetch.if_rdata", b_if_rdata, 32'h1122_3344);
                if_req = 1'b0;
            end
        end
        if_req  = 1'b1;
        if_addr = 32'h08;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check("flush.mem_en", 32'(b_mem_en), 32'(c == 1 || c == 7));
            check("flush.if_ack", 32'(b_if_ack), 32'(c == 11));
            if (c == 1) check("flush.mem_addr", b_mem_addr, 32'h08);
            if (c == 7) check("flush.new_addr", b_mem_addr, 32'h10);
            if (c < 11) check("flush.if_rdata", b_if_rdata, 32'h1122_3344);
            if (c == 11) begin
                check("flush.new_rdata", b_if_rdata, 32'hA5A5_5A5A);
                if_req = 1'b0;
            end
            if (c == 3) begin
                if_flush = 1'b1;
                if_req   = 1'b0;
            end
            if (c == 4) if_flush = 1'b0;
            if (c == 6) begin
                if_req  = 1'b1;
                if_addr = 32'h10;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
